video_timing_rx: RTL and testbench



---
 rtl/video_timing_rx.sv | 217 +++++++++++++++++++++
 tb/tb_video_timing_rx.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_rx.sv
// Sync-stream receiver: recovers active-area coordinates, measures line
// and frame geometry from hsync/vsync/DE, and reports lock status.
module video_timing_rx #(
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        de_in,
  output logic        de_out,
  output logic [11:0] hpos_out,
  output logic [11:0] vpos_out,
  output logic [11:0] htotal,
  output logic [11:0] hactive,
  output logic [11:0] vtotal,
  output logic [11:0] vactive,
  output logic        frame_start,
  output logic        locked,
  output logic        err,
  output logic        timeout
);

  localparam logic [11:0] TO_CNT = 12'(TIMEOUT);
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hfff) ? v : v + 12'd1;
  endfunction

  logic hs1_q, vs1_q, de1_q;
  logic hs2_q, vs2_q, de2_q;
  logic hs_edge, vs_edge, de_rise, de_fall;

  assign hs_edge = (hs1_q == HS_POL) && (hs2_q != HS_POL);
  assign vs_edge = (vs1_q == VS_POL) && (vs2_q != VS_POL);
  assign de_rise = de1_q && !de2_q;
  assign de_fall = !de1_q && de2_q;

  // Register raw inputs once and keep the previous sample for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs1_q <= 1'b0; vs1_q <= 1'b0; de1_q <= 1'b0;
      hs2_q <= 1'b0; vs2_q <= 1'b0; de2_q <= 1'b0;
    end else begin
      hs1_q <= hsync_in; vs1_q <= vsync_in; de1_q <= de_in;
      hs2_q <= hs1_q;    vs2_q <= vs1_q;    de2_q <= de1_q;
    end
  end

  logic        de_q, first_q;
  logic [11:0] hpos_q, vpos_q;

  // Active-area coordinates aligned with the delayed DE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_q <= 1'b0; first_q <= 1'b0;
      hpos_q <= '0; vpos_q <= '0;
    end else begin
      de_q <= de1_q;
      if (de_rise)    hpos_q <= '0;
      else if (de1_q) hpos_q <= sat_inc(hpos_q);
      if (vs_edge) begin
        vpos_q  <= '0;
        first_q <= !de_rise;
      end else if (de_rise) begin
        first_q <= 1'b0;
        if (!first_q) vpos_q <= sat_inc(vpos_q);
      end
    end
  end

  logic [11:0] lcnt_q, htotal_q, run_q, hactive_q;
  logic [11:0] ht_d;

  assign ht_d = sat_inc(lcnt_q);

  // Clocks per line and DE run length
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lcnt_q <= '0; htotal_q <= '0;
      run_q  <= '0; hactive_q <= '0;
    end else begin
      if (hs_edge) begin
        lcnt_q   <= '0;
        htotal_q <= ht_d;
      end else begin
        lcnt_q <= sat_inc(lcnt_q);
      end
      if (de_rise)    run_q <= 12'd1;
      else if (de1_q) run_q <= sat_inc(run_q);
      if (de_fall) hactive_q <= run_q;
    end
  end

  logic [11:0] hcnt_q, dcnt_q, vtotal_q, vactive_q, prev_vt_q, ht_first_q;
  logic        ht_seen_q, ht_bad_q, skip_q;
  logic [11:0] vt_d;
  logic        ht_mis, frame_ok;

  // A coincident hsync edge belongs to the frame that is closing
  assign vt_d     = hs_edge ? sat_inc(hcnt_q) : hcnt_q;
  assign ht_mis   = hs_edge && ht_seen_q && (ht_d != ht_first_q);
  assign frame_ok = !(ht_bad_q || ht_mis) &&
                    (skip_q || (vt_d == prev_vt_q));

  // Per-frame line/DE counts and line-length consistency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q <= '0; dcnt_q <= '0;
      vtotal_q <= '0; vactive_q <= '0;
      prev_vt_q <= '0; ht_first_q <= '0;
      ht_seen_q <= 1'b0; ht_bad_q <= 1'b0;
    end else if (vs_edge) begin
      vtotal_q  <= vt_d;
      vactive_q <= dcnt_q;
      prev_vt_q <= vt_d;
      hcnt_q    <= '0;
      dcnt_q    <= {11'd0, de_rise};
      ht_seen_q <= 1'b0;
      ht_bad_q  <= 1'b0;
    end else begin
      if (hs_edge) begin
        hcnt_q <= sat_inc(hcnt_q);
        if (!ht_seen_q) begin
          ht_first_q <= ht_d;
          ht_seen_q  <= 1'b1;
        end
      end
      if (ht_mis)  ht_bad_q <= 1'b1;
      if (de_rise) dcnt_q <= sat_inc(dcnt_q);
    end
  end

  state_t     state_q;
  logic [3:0] good_q, good_d;
  logic       locked_q, err_q, timeout_q, fs_q;
  logic       to_hit;

  assign good_d = good_q + 4'd1;
  assign to_hit = (lcnt_q == TO_CNT) && !hs_edge;

  // Lock state machine with registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SEARCH; good_q <= '0; skip_q <= 1'b0;
      locked_q <= 1'b0; err_q <= 1'b0;
      timeout_q <= 1'b0; fs_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      fs_q  <= vs_edge;
      if (hs_edge) timeout_q <= 1'b0;
      if (to_hit) begin
        state_q   <= SEARCH;
        locked_q  <= 1'b0;
        timeout_q <= 1'b1;
        good_q    <= '0;
        skip_q    <= 1'b0;
        err_q     <= (state_q == LOCKED);
      end else if (vs_edge) begin
        case (state_q)
          SEARCH: begin
            state_q <= ACQUIRE;
            good_q  <= '0;
            skip_q  <= 1'b1;
          end
          ACQUIRE: begin
            skip_q <= 1'b0;
            if (frame_ok) begin
              good_q <= good_d;
              if (good_d >= LOCK_N) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              good_q <= '0;
            end
          end
          LOCKED: begin
            if (!frame_ok) begin
              state_q  <= ACQUIRE;
              locked_q <= 1'b0;
              err_q    <= 1'b1;
              good_q   <= '0;
            end
          end
          default: begin
            state_q  <= SEARCH;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign de_out      = de_q;
  assign hpos_out    = hpos_q;
  assign vpos_out    = vpos_q;
  assign htotal      = htotal_q;
  assign hactive     = hactive_q;
  assign vtotal      = vtotal_q;
  assign vactive     = vactive_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign err         = err_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_video_timing_rx.sv
// Directed bench for video_timing_rx: an active-low and an active-high
// instance watch the same reduced-size stream and must agree on everything.
module tb_video_timing_rx;

  localparam int LL  = 80;
  localparam int HSW = 4;
  localparam int HBP = 12;
  localparam int HA  = 60;
  localparam int VT  = 16;
  localparam int VSW = 2;
  localparam int VBP = 4;
  localparam int VA  = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic hs_a = 1'b1, vs_a = 1'b1, de = 1'b0;
  logic hs_b, vs_b;

  logic        de_o   [2];
  logic [11:0] hpos_o [2];
  logic [11:0] vpos_o [2];
  logic [11:0] htot_o [2];
  logic [11:0] hact_o [2];
  logic [11:0] vtot_o [2];
  logic [11:0] vact_o [2];
  logic        fs_o   [2];
  logic        lk_o   [2];
  logic        err_o  [2];
  logic        to_o   [2];

  int total = 0;
  int bad = 0;
  int ln = 0, px = 0, long_ln = -1;
  bit en = 1'b0;
  int tcnt = 0;
  int last_hs_tick = 0;

  assign hs_b = ~hs_a;
  assign vs_b = ~vs_a;

  always #5 clk = ~clk;

  video_timing_rx #(.HS_POL(1'b0), .VS_POL(1'b0)) dut_a (
    .clk(clk), .reset(reset),
    .hsync_in(hs_a), .vsync_in(vs_a), .de_in(de),
    .de_out(de_o[0]), .hpos_out(hpos_o[0]), .vpos_out(vpos_o[0]),
    .htotal(htot_o[0]), .hactive(hact_o[0]),
    .vtotal(vtot_o[0]), .vactive(vact_o[0]),
    .frame_start(fs_o[0]), .locked(lk_o[0]),
    .err(err_o[0]), .timeout(to_o[0])
  );

  video_timing_rx #(.HS_POL(1'b1), .VS_POL(1'b1)) dut_b (
    .clk(clk), .reset(reset),
    .hsync_in(hs_b), .vsync_in(vs_b), .de_in(de),
    .de_out(de_o[1]), .hpos_out(hpos_o[1]), .vpos_out(vpos_o[1]),
    .htotal(htot_o[1]), .hactive(hact_o[1]),
    .vtotal(vtot_o[1]), .vactive(vact_o[1]),
    .frame_start(fs_o[1]), .locked(lk_o[1]),
    .err(err_o[1]), .timeout(to_o[1])
  );

  function automatic logic [76:0] snap(int i);
    return {de_o[i], hpos_o[i], vpos_o[i], htot_o[i], hact_o[i],
            vtot_o[i], vact_o[i], fs_o[i], lk_o[i], err_o[i], to_o[i]};
  endfunction

  task automatic tick();
    @(negedge clk);
    tcnt++;
    if (en) begin
      hs_a = !(px < HSW);
      vs_a = !(ln < VSW);
      de = (ln >= VBP) && (ln < VBP + VA) && (px >= HBP) && (px < HBP + HA);
      if (px == 0) last_hs_tick = tcnt;
      px++;
      if (px >= LL + ((ln == long_ln) ? 1 : 0)) begin
        px = 0;
        ln = (ln + 1) % VT;
      end
    end else begin
      hs_a = 1'b1;
      vs_a = 1'b1;
      de = 1'b0;
    end
  endtask

  task automatic advance_to(int l, int p);
    int n;
    n = 0;
    while (!(ln == l && px == p) && n < 3000) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (snap(i) !== '0) begin
        bad++;
        $display("FAIL reset_outputs[%0d]: got %h want 0", i, snap(i));
      end
    end
    reset = 1'b0;
    repeat (3) tick();
    en = 1'b1;
    ln = 0;
    px = 0;
  endtask

  task automatic test_lock(string tag, int skip);
    int fs_n [2];
    int er_n [2];
    for (int e = 1 + skip; e <= 3; e++) begin
      advance_to(0, 0);
      if (e == 3) begin
        for (int i = 0; i < 2; i++) begin
          total++;
          if (lk_o[i] !== 1'b0) begin
            bad++;
            $display("FAIL %s early_lock[%0d]: got %b want 0", tag, i, lk_o[i]);
          end
        end
      end
      tick();
    end
    fs_n = '{0, 0};
    er_n = '{0, 0};
    repeat (6) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        fs_n[i] += int'(fs_o[i]);
        er_n[i] += int'(err_o[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (lk_o[i] !== 1'b1) begin
        bad++;
        $display("FAIL %s lock[%0d]: got %b want 1", tag, i, lk_o[i]);
      end
      total++;
      if (fs_n[i] != 1 || er_n[i] != 0) begin
        bad++;
        $display("FAIL %s pulses[%0d]: got fs=%0d err=%0d want fs=1 err=0",
                 tag, i, fs_n[i], er_n[i]);
      end
      total++;
      if (htot_o[i] !== 12'd80 || hact_o[i] !== 12'd60 ||
          vtot_o[i] !== 12'd16 || vact_o[i] !== 12'd10) begin
        bad++;
        $display("FAIL %s geometry[%0d]: got %0d/%0d/%0d/%0d want 80/60/16/10",
                 tag, i, htot_o[i], hact_o[i], vtot_o[i], vact_o[i]);
      end
    end
  endtask

  task automatic test_coords();
    advance_to(VBP, HBP);
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (de_o[i] !== 1'b1 || hpos_o[i] !== 12'd0 || vpos_o[i] !== 12'd0) begin
        bad++;
        $display("FAIL first_pixel[%0d]: got de=%b h=%0d v=%0d want 1/0/0",
                 i, de_o[i], hpos_o[i], vpos_o[i]);
      end
    end
    advance_to(VBP + 1, HBP + 7);
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (de_o[i] !== 1'b1 || hpos_o[i] !== 12'd7 || vpos_o[i] !== 12'd1) begin
        bad++;
        $display("FAIL mid_pixel[%0d]: got de=%b h=%0d v=%0d want 1/7/1",
                 i, de_o[i], hpos_o[i], vpos_o[i]);
      end
    end
    advance_to(VBP + VA - 1, HBP + HA - 1);
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (de_o[i] !== 1'b1 || hpos_o[i] !== 12'd799 - 12'd740 ||
          vpos_o[i] !== 12'd9) begin
        bad++;
        $display("FAIL last_pixel[%0d]: got de=%b h=%0d v=%0d want 1/59/9",
                 i, de_o[i], hpos_o[i], vpos_o[i]);
      end
    end
    repeat (4) tick();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (de_o[i] !== 1'b0 || hpos_o[i] !== 12'd59) begin
        bad++;
        $display("FAIL hold_hpos[%0d]: got de=%b h=%0d want 0/59",
                 i, de_o[i], hpos_o[i]);
      end
    end
  endtask

  task automatic test_long_line();
    int er_n [2];
    advance_to(0, 0);
    tick();
    long_ln = 7;
    advance_to(8, 10);
    long_ln = -1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (htot_o[i] !== 12'd81) begin
        bad++;
        $display("FAIL long_htotal[%0d]: got %0d want 81", i, htot_o[i]);
      end
    end
    advance_to(0, 0);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (lk_o[i] !== 1'b1) begin
        bad++;
        $display("FAIL pre_long_lock[%0d]: got %b want 1", i, lk_o[i]);
      end
    end
    tick();
    er_n = '{0, 0};
    repeat (6) begin
      tick();
      for (int i = 0; i < 2; i++) er_n[i] += int'(err_o[i]);
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (er_n[i] != 1 || lk_o[i] !== 1'b0) begin
        bad++;
        $display("FAIL long_unlock[%0d]: got err=%0d lock=%b want 1/0",
                 i, er_n[i], lk_o[i]);
      end
    end
    test_lock("relock_long", 1);
  endtask

  task automatic test_timeout();
    int er_n [2];
    int t0;
    advance_to(5, 76);
    en = 1'b0;
    t0 = last_hs_tick;
    er_n = '{0, 0};
    while (tcnt < t0 + 4030) begin
      tick();
      for (int i = 0; i < 2; i++) er_n[i] += int'(err_o[i]);
      if (tcnt == t0 + 3995) begin
        for (int i = 0; i < 2; i++) begin
          total++;
          if (to_o[i] !== 1'b0 || lk_o[i] !== 1'b1) begin
            bad++;
            $display("FAIL pre_timeout[%0d]: got to=%b lock=%b want 0/1",
                     i, to_o[i], lk_o[i]);
          end
        end
      end
      if (tcnt == t0 + 4010) begin
        for (int i = 0; i < 2; i++) begin
          total++;
          if (to_o[i] !== 1'b1 || lk_o[i] !== 1'b0) begin
            bad++;
            $display("FAIL timeout[%0d]: got to=%b lock=%b want 1/0",
                     i, to_o[i], lk_o[i]);
          end
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (er_n[i] != 1 || htot_o[i] !== 12'd80) begin
        bad++;
        $display("FAIL timeout_err[%0d]: got err=%0d htotal=%0d want 1/80",
                 i, er_n[i], htot_o[i]);
      end
    end
    en = 1'b1;
    ln = 0;
    px = 0;
    tick();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (to_o[i] !== 1'b1) begin
        bad++;
        $display("FAIL timeout_hold[%0d]: got %b want 1", i, to_o[i]);
      end
    end
    repeat (2) tick();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (to_o[i] !== 1'b0) begin
        bad++;
        $display("FAIL timeout_clear[%0d]: got %b want 0", i, to_o[i]);
      end
    end
    test_lock("relock_timeout", 1);
  endtask

  task automatic test_reset_mid();
    advance_to(8, 30);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (lk_o[i] !== 1'b1) begin
        bad++;
        $display("FAIL pre_reset_lock[%0d]: got %b want 1", i, lk_o[i]);
      end
    end
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (snap(i) !== '0) begin
        bad++;
        $display("FAIL async_reset[%0d]: got %h want 0", i, snap(i));
      end
    end
    repeat (3) tick();
    reset = 1'b0;
    test_lock("relock_reset", 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lock("nominal", 0);
    test_coords();
    test_long_line();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
